// File: rtl/adc_spi_pkg.sv
// Shared types and constants for the MCP3002-style ADC SPI master.
// Holds the FSM state encoding, the fixed command bits of the ADC request,
// the frame positions that carry result data, and the sample typedef.
package adc_spi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StShift,
    StHold
  } state_e;

  // Command bits sent at frame indices 0..3; index 2 is the channel (ODD) bit.
  localparam logic CMD_START = 1'b1;
  localparam logic CMD_SGL   = 1'b1;
  localparam logic CMD_MSBF  = 1'b1;

  // Frame indices whose rising-edge miso bits form the result, MSB first.
  localparam int unsigned DATA_FIRST_IDX = 5;
  localparam int unsigned DATA_LAST_IDX  = 14;

  localparam int unsigned SAMPLE_W = 10;
  typedef logic [SAMPLE_W-1:0] sample_t;

  // mosi value for a given frame index; indices past the command are zero.
  function automatic logic cmd_bit(input int idx, input logic odd);
    logic b;
    case (idx)
      0:       b = CMD_START;
      1:       b = CMD_SGL;
      2:       b = odd;
      3:       b = CMD_MSBF;
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/adc_spi_master_clk_div.sv
// spi_clk_div: serial clock generator for the ADC SPI master.
// Ports:
//   clk, reset       system clock, async active-high reset
//   en               count enable; when low the count and sck are held at 0
//   toggle           allow sck to toggle on terminal count
//   tc               one-cycle strobe every CLK_DIV enabled cycles
//   sck              serial clock, idles low
//   sck_rise/fall    one-cycle strobes in the cycle whose edge changes sck
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic toggle,
  output logic tc,
  output logic sck,
  output logic sck_rise,
  output logic sck_fall
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             sck_q;

  assign tc       = en && (cnt_q == CNT_LAST);
  assign sck_rise = tc && toggle && !sck_q;
  assign sck_fall = tc && toggle && sck_q;
  assign sck      = sck_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else if (!en) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (tc && toggle) begin
        sck_q <= ~sck_q;
      end
    end
  end

endmodule

// File: rtl/adc_spi_master.sv
// adc_spi_master: periodic SPI mode-0 reader for an MCP3002-style ADC.
// Each period tick runs one frame (cs_n low, FRAME_BITS sck pulses) and
// presents the 10-bit result on a valid/ready interface.
// Optional build macro ADC_AVERAGE_EN: average four captures per output.
// Ports:
//   clk, reset            system clock, async active-high reset
//   enable                allows new frames to start
//   channel               ADC channel (ODD bit), latched at frame start
//   miso                  ADC data out
//   sck, mosi, cs_n       SPI outputs to the ADC
//   sample, sample_valid  result and its valid flag
//   sample_ready          consumer accept
//   busy                  frame in progress
//   overrun               sticky: an unread sample was overwritten
module adc_spi_master
  import adc_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 20,
  parameter int unsigned SAMPLE_PERIOD = 40000,
  parameter int unsigned FRAME_BITS    = 16,
  parameter int unsigned DATA_BITS     = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 channel,
  input  logic                 miso,
  output logic                 sck,
  output logic                 mosi,
  output logic                 cs_n,
  output logic [DATA_BITS-1:0] sample,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic                 busy,
  output logic                 overrun
);

  localparam int unsigned TIMER_W = $clog2(SAMPLE_PERIOD);
  localparam int unsigned IDX_W   = $clog2(FRAME_BITS);
  localparam int unsigned HOLD_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SAMPLE_PERIOD - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(FRAME_BITS - 1);
  localparam logic [IDX_W-1:0]   IDX_FIRST_D = IDX_W'(DATA_FIRST_IDX);
  localparam logic [IDX_W-1:0]   IDX_LAST_D  = IDX_W'(DATA_LAST_IDX);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(CLK_DIV - 1);

  logic [TIMER_W-1:0]   timer_q;
  logic                 tick_q;
  state_e               state_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 odd_q;
  logic [DATA_BITS-1:0] rx_q;
  logic [HOLD_W-1:0]    hold_q;

  logic div_en, div_toggle, div_tc, sck_rise, sck_fall;

  assign div_en     = (state_q == StSetup) || (state_q == StShift);
  assign div_toggle = (state_q == StShift);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk      (clk),
    .reset    (reset),
    .en       (div_en),
    .toggle   (div_toggle),
    .tc       (div_tc),
    .sck      (sck),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  // Period timer; a tick seen outside StIdle is simply ignored by the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
      tick_q  <= 1'b0;
    end else if (!enable) begin
      timer_q <= '0;
      tick_q  <= 1'b0;
    end else if (timer_q == TIMER_LAST) begin
      timer_q <= '0;
      tick_q  <= 1'b1;
    end else begin
      timer_q <= timer_q + 1'b1;
      tick_q  <= 1'b0;
    end
  end

`ifdef ADC_AVERAGE_EN
  logic [DATA_BITS+1:0] acc_q;
  logic [1:0]           avg_cnt_q;
  logic [DATA_BITS+1:0] avg_sum;
  assign avg_sum = acc_q + {2'b00, rx_q};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      odd_q        <= 1'b0;
      rx_q         <= '0;
      hold_q       <= '0;
      cs_n         <= 1'b1;
      mosi         <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
`ifdef ADC_AVERAGE_EN
      acc_q        <= '0;
      avg_cnt_q    <= '0;
`endif
    end else begin
      // Acceptance clears valid; a capture below in the same cycle overrides it.
      if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (tick_q) begin
            state_q <= StSetup;
            busy    <= 1'b1;
            cs_n    <= 1'b0;
            odd_q   <= channel;
            mosi    <= cmd_bit(0, channel);
            idx_q   <= '0;
            rx_q    <= '0;
          end
        end
        StSetup: begin
          if (div_tc) begin
            state_q <= StShift;
          end
        end
        StShift: begin
          if (sck_rise && (idx_q >= IDX_FIRST_D) && (idx_q <= IDX_LAST_D)) begin
            rx_q <= {rx_q[DATA_BITS-2:0], miso};
          end
          if (sck_fall) begin
            if (idx_q == IDX_LAST) begin
              state_q <= StHold;
              hold_q  <= '0;
              mosi    <= 1'b0;
            end else begin
              idx_q <= idx_q + 1'b1;
              mosi  <= cmd_bit(int'(idx_q) + 1, odd_q);
            end
          end
        end
        StHold: begin
          if (hold_q == HOLD_LAST) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            cs_n    <= 1'b1;
`ifdef ADC_AVERAGE_EN
            if (avg_cnt_q == 2'd3) begin
              sample       <= avg_sum[DATA_BITS+1:2];
              sample_valid <= 1'b1;
              if (sample_valid && !sample_ready) begin
                overrun <= 1'b1;
              end
              acc_q     <= '0;
              avg_cnt_q <= '0;
            end else begin
              acc_q     <= avg_sum;
              avg_cnt_q <= avg_cnt_q + 1'b1;
            end
`else
            sample       <= rx_q;
            sample_valid <= 1'b1;
            if (sample_valid && !sample_ready) begin
              overrun <= 1'b1;
            end
`endif
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_master.sv
module tb_adc_spi_master;
  import adc_spi_pkg::*;

  localparam int unsigned CLK_DIV       = 2;
  localparam int unsigned SAMPLE_PERIOD = 100;
  localparam int unsigned FRAME_BITS    = 16;
  localparam int unsigned DATA_BITS     = 10;

  logic                 clk = 1'b0;
  logic                 reset, enable, channel, miso, sample_ready;
  logic                 sck, mosi, cs_n, sample_valid, busy, overrun;
  logic [DATA_BITS-1:0] sample;

  int tests = 0;
  int fails = 0;

  adc_spi_master #(
    .CLK_DIV       (CLK_DIV),
    .SAMPLE_PERIOD (SAMPLE_PERIOD),
    .FRAME_BITS    (FRAME_BITS),
    .DATA_BITS     (DATA_BITS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .channel      (channel),
    .miso         (miso),
    .sck          (sck),
    .mosi         (mosi),
    .cs_n         (cs_n),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // ADC model: after the fall that moves the frame to index k (5..14) it drives
  // bit 14-k of the programmed value; rise-side monitor records mosi.
  sample_t    adc_val = '0;
  int         falls = 0;
  int         rises = 0;
  logic [3:0] mosi_at = '0;

  initial miso = 1'b0;

  always @(negedge cs_n) begin
    falls = 0;
    rises = 0;
    miso  = 1'b0;
  end

  always @(negedge sck) begin
    falls++;
    if (falls >= 5 && falls <= 14) miso = adc_val[14-falls];
    else miso = 1'b0;
  end

  always @(posedge sck) begin
    if (rises < 4) mosi_at[rises] = mosi;
    rises++;
  end

  // Runs one frame from idle: cycles to cs_n fall, cycles cs_n stays low.
  task automatic wait_frame(input sample_t val, output int to_start, output int low,
                            output bit ok);
    ok = 1'b1;
    adc_val = val;
    to_start = 0;
    low = 0;
    while (cs_n !== 1'b0 && to_start < 400) begin
      @(negedge clk);
      to_start++;
    end
    if (cs_n !== 1'b0) begin
      tests++; fails++; ok = 1'b0;
      $display("FAIL frame_start_timeout: cs_n=%b after %0d cycles, required 0", cs_n, to_start);
      return;
    end
    while (cs_n !== 1'b1 && low < 300) begin
      @(negedge clk);
      low++;
    end
    if (cs_n !== 1'b1) begin
      tests++; fails++; ok = 1'b0;
      $display("FAIL frame_end_timeout: cs_n=%b after %0d cycles, required 1", cs_n, low);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; channel = 1'b0; sample_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (sck !== 1'b0) begin fails++; $display("FAIL rst_sck: got %b want 0", sck); end
    tests++; if (cs_n !== 1'b1) begin fails++; $display("FAIL rst_cs_n: got %b want 1", cs_n); end
    tests++; if (mosi !== 1'b0) begin fails++; $display("FAIL rst_mosi: got %b want 0", mosi); end
    tests++; if (sample !== 10'h000) begin fails++; $display("FAIL rst_sample: got %h want 000", sample); end
    tests++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", sample_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL rst_overrun: got %b want 0", overrun); end
    reset = 1'b0;
  endtask

  // Timer reaches 99 after 99 edges, ticks on edge 100, cs_n falls on edge 101.
  // Frame: 2 setup + 64 shift + 2 hold = 68 cycles with cs_n low.
  task automatic test_single_frame();
    int ts, low; bit ok;
    enable = 1'b1; channel = 1'b0; sample_ready = 1'b1;
    wait_frame(10'h2A5, ts, low, ok);
    if (ok) begin
      tests++; if (ts != 101) begin fails++; $display("FAIL first_cs_fall: got %0d cycles want 101", ts); end
      tests++; if (low != 68) begin fails++; $display("FAIL frame_len: got %0d want 68", low); end
      tests++; if (rises != 16) begin fails++; $display("FAIL sck_rises: got %0d want 16", rises); end
      tests++; if (mosi_at !== 4'b1011) begin fails++; $display("FAIL cmd_ch0: got %b want 1011", mosi_at); end
      tests++; if (sample !== 10'h2A5) begin fails++; $display("FAIL sample_2a5: got %h want 2a5", sample); end
      tests++; if (sample_valid !== 1'b1) begin fails++; $display("FAIL valid_set: got %b want 1", sample_valid); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_done: got %b want 0", busy); end
      @(negedge clk);
      tests++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL valid_one_cycle: got %b want 0", sample_valid); end
      tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL no_overrun: got %b want 0", overrun); end
    end
  endtask

  task automatic test_overrun();
    int ts, low; bit ok;
    sample_ready = 1'b0;
    wait_frame(10'h155, ts, low, ok);
    if (ok) begin
      tests++; if (sample !== 10'h155) begin fails++; $display("FAIL sample_155: got %h want 155", sample); end
      tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL overrun_early: got %b want 0", overrun); end
    end
    channel = 1'b1;
    wait_frame(10'h0AA, ts, low, ok);
    if (ok) begin
      tests++; if (mosi_at !== 4'b1111) begin fails++; $display("FAIL cmd_ch1: got %b want 1111", mosi_at); end
      tests++; if (sample !== 10'h0AA) begin fails++; $display("FAIL sample_0aa: got %h want 0aa", sample); end
      tests++; if (sample_valid !== 1'b1) begin fails++; $display("FAIL valid_held: got %b want 1", sample_valid); end
      tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_set: got %b want 1", overrun); end
    end
    channel = 1'b0;
    sample_ready = 1'b1;
    @(negedge clk);
    tests++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL valid_accept: got %b want 0", sample_valid); end
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_reset_midframe();
    int ts, low, n; bit ok;
    n = 0;
    while (!(cs_n === 1'b0 && rises >= 7) && n < 400) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!(cs_n === 1'b0 && rises >= 7)) begin
      fails++; $display("FAIL rise7_timeout: rises=%0d want 7", rises);
    end
    reset = 1'b1;
    #1;
    tests++; if (cs_n !== 1'b1) begin fails++; $display("FAIL mid_rst_cs_n: got %b want 1", cs_n); end
    tests++; if (sck !== 1'b0) begin fails++; $display("FAIL mid_rst_sck: got %b want 0", sck); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL mid_rst_overrun: got %b want 0", overrun); end
    @(negedge clk);
    reset = 1'b0;
    wait_frame(10'h3C9, ts, low, ok);
    if (ok) begin
      tests++; if (ts != 101) begin fails++; $display("FAIL post_rst_start: got %0d want 101", ts); end
      tests++; if (rises != 16) begin fails++; $display("FAIL post_rst_rises: got %0d want 16", rises); end
      tests++; if (sample !== 10'h3C9) begin fails++; $display("FAIL post_rst_sample: got %h want 3c9", sample); end
    end
  endtask

  task automatic test_enable_drop();
    int n, starts;
    adc_val = 10'h1E7;
    n = 0;
    while (cs_n !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    enable = 1'b0;
    n = 0;
    while (cs_n !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    tests++; if (sample !== 10'h1E7) begin fails++; $display("FAIL drop_sample: got %h want 1e7", sample); end
    tests++; if (sample_valid !== 1'b1) begin fails++; $display("FAIL drop_valid: got %b want 1", sample_valid); end
    starts = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (cs_n === 1'b0) starts++;
    end
    tests++; if (starts != 0) begin fails++; $display("FAIL drop_no_frames: got %0d low cycles want 0", starts); end
  endtask

`ifdef ADC_AVERAGE_EN
  task automatic test_average();
    int ts, low; bit ok;
    sample_t vals [4];
    vals[0] = 10'h100; vals[1] = 10'h104; vals[2] = 10'h108; vals[3] = 10'h10C;
    enable = 1'b1; channel = 1'b0; sample_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_frame(vals[i], ts, low, ok);
      if (ok && i < 3) begin
        tests++;
        if (sample_valid !== 1'b0) begin
          fails++; $display("FAIL avg_early_valid%0d: got %b want 0", i, sample_valid);
        end
      end
    end
    tests++; if (sample_valid !== 1'b1) begin fails++; $display("FAIL avg_valid: got %b want 1", sample_valid); end
    tests++; if (sample !== 10'h106) begin fails++; $display("FAIL avg_sample: got %h want 106", sample); end
    @(negedge clk);
    tests++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL avg_accept: got %b want 0", sample_valid); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL avg_overrun: got %b want 0", overrun); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef ADC_AVERAGE_EN
    test_average();
`else
    test_single_frame();
    test_overrun();
    test_reset_midframe();
    test_enable_drop();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
